// File: rtl/button_updown_counter_pkg.sv
// counter_pkg: shared types and constants for button_updown_counter.
// Optional feature macro used in this slice: BUTTON_DEBOUNCE_EN.
package counter_pkg;

  // Operation decoded from the button presses seen in one cycle.
  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC,
    CNT_LOAD
  } cnt_op_t;

  // Idle level of an active-low push-button.
  localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/button_updown_counter_if.sv
// button_updown_counter_if: button inputs, load value and count/flag outputs.
// master = button/board side, slave = counter.
interface button_updown_counter_if #(
  parameter int W = 4
);
  logic         btn_inc_n;
  logic         btn_dec_n;
  logic         btn_load_n;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         at_max;
  logic         at_min;
  logic         changed;

  modport master (
    output btn_inc_n, btn_dec_n, btn_load_n, load_val,
    input  count, at_max, at_min, changed
  );

  modport slave (
    input  btn_inc_n, btn_dec_n, btn_load_n, load_val,
    output count, at_max, at_min, changed
  );
endinterface

// File: rtl/button_updown_counter_btn.sv
// btn_conditioner: 2-flop synchroniser, optional debounce filter
// (BUTTON_DEBOUNCE_EN) and falling-edge detect for one active-low button.
// press is a one-cycle pulse on a filtered 1->0 transition.
module btn_conditioner
  import counter_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic filt;

  // Synchroniser stage inputs.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
  end

  // Synchroniser flops, released level on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= BTN_RELEASED;
      sync2_q <= BTN_RELEASED;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef BUTTON_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_C = CW'(DEB_CYCLES);

  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing cycles; flip the filtered level when the
  // count reaches DEB_CYCLES, any agreeing cycle restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == DEB_C) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= BTN_RELEASED;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES > 0);
  assign filt = sync2_q;
`endif

  // Previous filtered level and falling-edge pulse.
  always_comb begin
    prev_d = filt;
    press  = prev_q & ~filt;
  end

  // Edge-detect history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= BTN_RELEASED;
    else     prev_q <= prev_d;
  end

endmodule

// File: rtl/button_updown_counter.sv
// button_updown_counter: push-button driven W-bit up/down/load counter with
// wrap or saturate at bounds. Debounce enabled by BUTTON_DEBOUNCE_EN.
module button_updown_counter
  import counter_pkg::*;
#(
  parameter int W          = 4,
  parameter int MAX_VAL    = (1 << W) - 1,
  parameter int WRAP       = 1,
  parameter int DEB_CYCLES = 16
) (
  input logic                  clk,
  input logic                  rst,
  button_updown_counter_if.slave bus
);

  localparam logic [W-1:0] MAX_C = MAX_VAL[W-1:0];

  logic         press_inc, press_dec, press_load;
  cnt_op_t      op;
  logic [W-1:0] count_q, count_d;
  logic         changed_q, changed_d;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
    .clk(clk), .rst(rst), .btn_n(bus.btn_inc_n), .press(press_inc)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_dec (
    .clk(clk), .rst(rst), .btn_n(bus.btn_dec_n), .press(press_dec)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_load (
    .clk(clk), .rst(rst), .btn_n(bus.btn_load_n), .press(press_load)
  );

  // Priority decode: load beats everything, inc+dec together cancel.
  always_comb begin
    op = CNT_HOLD;
    if (press_load)                  op = CNT_LOAD;
    else if (press_inc && press_dec) op = CNT_HOLD;
    else if (press_inc)              op = CNT_INC;
    else if (press_dec)              op = CNT_DEC;
  end

  // Next count: bounds are tested before stepping so nothing overflows W bits.
  always_comb begin
    count_d = count_q;
    case (op)
      CNT_LOAD: count_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
      CNT_INC: begin
        if (count_q >= MAX_C) count_d = (WRAP != 0) ? '0 : count_q;
        else                  count_d = count_q + W'(1);
      end
      CNT_DEC: begin
        if (count_q == '0) count_d = (WRAP != 0) ? MAX_C : count_q;
        else               count_d = count_q - W'(1);
      end
      default: count_d = count_q;
    endcase
    changed_d = (count_d != count_q);
  end

  // Count and change-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= MAX_C;
      changed_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      changed_q <= changed_d;
    end
  end

  // Output drive and flag decode.
  always_comb begin
    bus.count   = count_q;
    bus.changed = changed_q;
    bus.at_max  = (count_q == MAX_C);
    bus.at_min  = (count_q == '0);
  end

endmodule

// File: tb/tb_button_updown_counter.sv
// Directed bench for button_updown_counter. dut_a: W=4, MAX_VAL=15, WRAP=1.
// dut_b: W=4, MAX_VAL=9, WRAP=0. Debounce timing follows BUTTON_DEBOUNCE_EN.
module tb_button_updown_counter;

`ifdef BUTTON_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  localparam int M_INC  = 1;
  localparam int M_DEC  = 2;
  localparam int M_LOAD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  button_updown_counter_if #(.W(4)) ifa ();
  button_updown_counter_if #(.W(4)) ifb ();

  button_updown_counter #(.W(4), .MAX_VAL(15), .WRAP(1), .DEB_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  button_updown_counter #(.W(4), .MAX_VAL(9), .WRAP(0), .DEB_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cnt_of(input int d);
    return (d == 0) ? ifa.count : ifb.count;
  endfunction

  function automatic logic chg_of(input int d);
    return (d == 0) ? ifa.changed : ifb.changed;
  endfunction

  task automatic drive(input int d, input int mask, input logic lvl);
    if (d == 0) begin
      if (mask & M_INC)  ifa.btn_inc_n  = lvl;
      if (mask & M_DEC)  ifa.btn_dec_n  = lvl;
      if (mask & M_LOAD) ifa.btn_load_n = lvl;
    end else begin
      if (mask & M_INC)  ifb.btn_inc_n  = lvl;
      if (mask & M_DEC)  ifb.btn_dec_n  = lvl;
      if (mask & M_LOAD) ifb.btn_load_n = lvl;
    end
  endtask

  // Press buttons in mask together, hold, release; check latency and pulses.
  task automatic do_press(input string tag, input int d, input int mask, input int hold,
                          input logic [3:0] old_v, input logic [3:0] new_v, input logic chg);
    @(negedge clk);
    drive(d, mask, 1'b0);
    repeat (LAT) @(posedge clk);
    #1 check({tag, ".before"}, cnt_of(d), old_v);
    @(posedge clk);
    #1 check({tag, ".after"}, cnt_of(d), new_v);
    check({tag, ".changed"}, chg_of(d), chg);
    @(posedge clk);
    #1 check({tag, ".pulse_end"}, chg_of(d), 1'b0);
    repeat (hold) @(posedge clk);
    #1 check({tag, ".no_repeat"}, cnt_of(d), new_v);
    @(negedge clk);
    drive(d, mask, 1'b1);
    repeat (LAT + 4) @(posedge clk);
    #1 check({tag, ".release"}, cnt_of(d), new_v);
    check({tag, ".release_chg"}, chg_of(d), 1'b0);
  endtask

  initial begin
    drive(0, 7, 1'b1);
    drive(1, 7, 1'b1);
    ifa.load_val = 4'd0;
    ifb.load_val = 4'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.count_a", ifa.count, 4'd15);
    check("rst.at_max_a", ifa.at_max, 1'b1);
    check("rst.at_min_a", ifa.at_min, 1'b0);
    check("rst.changed_a", ifa.changed, 1'b0);
    check("rst.count_b", ifb.count, 4'd9);
    check("rst.at_max_b", ifb.at_max, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Saturating instance, MAX_VAL=9
    ifb.load_val = 4'd12;
    do_press("b.load12", 1, M_LOAD, 3, 4'd9, 4'd9, 1'b0);
    check("b.load12.at_max", ifb.at_max, 1'b1);
    do_press("b.inc_sat", 1, M_INC, 3, 4'd9, 4'd9, 1'b0);
    ifb.load_val = 4'd0;
    do_press("b.load0", 1, M_LOAD, 3, 4'd9, 4'd0, 1'b1);
    do_press("b.dec_sat", 1, M_DEC, 3, 4'd0, 4'd0, 1'b0);
    check("b.dec_sat.at_min", ifb.at_min, 1'b1);

    // Wrapping instance
    do_press("a.dec1", 0, M_DEC, 3, 4'd15, 4'd14, 1'b1);
    do_press("a.dec2", 0, M_DEC, 3, 4'd14, 4'd13, 1'b1);
    do_press("a.dec3", 0, M_DEC, 3, 4'd13, 4'd12, 1'b1);
    ifa.load_val = 4'd0;
    do_press("a.load0", 0, M_LOAD, 3, 4'd12, 4'd0, 1'b1);
    check("a.at_min", ifa.at_min, 1'b1);
    do_press("a.dec_wrap", 0, M_DEC, 3, 4'd0, 4'd15, 1'b1);
    do_press("a.inc_wrap", 0, M_INC, 3, 4'd15, 4'd0, 1'b1);
    ifa.load_val = 4'd7;
    do_press("a.load7", 0, M_LOAD, 3, 4'd0, 4'd7, 1'b1);

    // Async reset mid-cycle
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("a.async_rst", ifa.count, 4'd15);
    check("a.async_rst.at_max", ifa.at_max, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Simultaneous presses
    ifa.load_val = 4'd5;
    do_press("a.load5", 0, M_LOAD, 3, 4'd15, 4'd5, 1'b1);
    do_press("a.inc_dec", 0, M_INC | M_DEC, 3, 4'd5, 4'd5, 1'b0);
    ifa.load_val = 4'd3;
    do_press("a.load_inc", 0, M_LOAD | M_INC, 3, 4'd5, 4'd3, 1'b1);

`ifdef BUTTON_DEBOUNCE_EN
    // 3-cycle glitch is filtered out
    @(negedge clk);
    drive(0, M_DEC, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(0, M_DEC, 1'b1);
    repeat (12) @(posedge clk);
    #1 check("a.glitch", ifa.count, 4'd3);
    check("a.glitch.changed", ifa.changed, 1'b0);
`endif

    // Long hold from 15: single step, no auto-repeat
    ifa.load_val = 4'd15;
    do_press("a.load15", 0, M_LOAD, 3, 4'd3, 4'd15, 1'b1);
    do_press("a.hold20", 0, M_DEC, 20, 4'd15, 4'd14, 1'b1);

    // Button held through reset release is a fresh press
    @(negedge clk);
    rst = 1'b1;
    drive(0, M_INC, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("a.held_rst.in_rst", ifa.count, 4'd15);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT) @(posedge clk);
    #1 check("a.held_rst.before", ifa.count, 4'd15);
    @(posedge clk);
    #1 check("a.held_rst.after", ifa.count, 4'd0);
    check("a.held_rst.changed", ifa.changed, 1'b1);
    repeat (10) @(posedge clk);
    #1 check("a.held_rst.no_repeat", ifa.count, 4'd0);
    @(negedge clk);
    drive(0, M_INC, 1'b1);
    repeat (LAT + 4) @(posedge clk);
    #1 check("a.held_rst.release", ifa.count, 4'd0);
    check("a.held_rst.release_chg", ifa.changed, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_updown_counter.md
# button_updown_counter

Parametrised, fully synchronous up/down counter driven by push-buttons. It is the next-generation replacement for the lab's edge-clocked decrement counter. Active-low buttons are synchronised, optionally debounced, and converted to one-cycle press pulses. These pulses increment, decrement or load a W-bit count with selectable wrap or saturate behaviour. The block sits between board push-buttons and display/decoder logic such as 7-segment drivers.

## Interface
- W, 4, count width in bits (W ≥ 2)
- MAX_VAL, 2**W-1, upper count bound; legal range 1..2**W-1
- WRAP, 1, 1 = wrap at bounds, 0 = saturate at bounds
- DEB_CYCLES, 16, stable-cycle count required by the debounce filter (≥ 1)
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- btn_inc_n  in  1  increment button, active-low, asynchronous to clk
- btn_dec_n  in  1  decrement button, active-low, asynchronous to clk
- btn_load_n  in  1  load button, active-low, asynchronous to clk
- load_val  in  W  value loaded on a load press; quasi-static
- count  out  W  current count
- at_max  out  1  count == MAX_VAL
- at_min  out  1  count == 0
- changed  out  1  one-cycle pulse in the cycle after count changes

## Operation
- Each button passes through a 2-flop synchroniser, then the optional debounce filter, then a falling-edge detector. A press is a one-cycle pulse on a filtered 1→0 transition. Release generates nothing.
- Holding a button gives exactly one press. There is no auto-repeat.
- Per-cycle priority: load press > (inc and dec pressed together → no change) > inc > dec.
- Load: count ← load_val if load_val ≤ MAX_VAL, otherwise count ← MAX_VAL.
- Inc at MAX_VAL: WRAP=1 → 0; WRAP=0 → hold.
- Dec at 0: WRAP=1 → MAX_VAL; WRAP=0 → hold.
- Arithmetic is W-bit unsigned. Intermediate results never exceed W bits because the bounds are compared before the add or subtract.
- changed asserts only when the count value actually differs. Saturated holds, simultaneous inc+dec, and loads of an equal value do not assert it.
- at_max and at_min are combinational decodes of the count register.

## Timing
- Reset values:
  - count = MAX_VAL
  - at_max = 1
  - at_min = 0
  - changed = 0
  - synchroniser and filter flops = 1 (released)
  - debounce counters = 0
- Reset is asynchronous assert and synchronous-release capable. Asserting rst mid-press discards the press.
- A button held low through reset deassertion counts as a fresh press. Count steps once after the normal latency.
- Latency without debounce: button first sampled low at edge k → count updates at edge k+2 → changed high during cycle k+2..k+3.
- Latency with debounce: count updates at edge k+2+DEB_CYCLES, provided the button stays low for the whole window.
- Any glitch shorter than DEB_CYCLES cycles (post-synchroniser) restarts the filter and produces no press.
- Minimum press-to-press spacing equals the full latency plus release time. Presses on different buttons in the same cycle are resolved by the priority above.

## Configuration
- Macro: BUTTON_DEBOUNCE_EN.
- Defined: each button has a debounce filter. A counter of width $clog2(DEB_CYCLES+1) counts consecutive cycles in which the synchronised input differs from the filtered output. The filtered output flips when the counter reaches DEB_CYCLES.
- Undefined: the filter is omitted, the filtered output equals the synchroniser output, and DEB_CYCLES is ignored. This mode is used for simulation and fast regression.

## Structure
- Package counter_pkg holds:
  - typedef enum {CNT_HOLD, CNT_INC, CNT_DEC, CNT_LOAD} cnt_op_t (decoded per-cycle operation)
  - constant BTN_RELEASED = 1'b1
- Sub-module btn_conditioner: synchroniser, optional debounce and falling-edge detect for one button. It has parameter DEB_CYCLES, ports clk, rst, btn_n, press. It is instantiated three times.
- The top level holds the priority decode to cnt_op_t, the bound/wrap logic, the count register, flags and changed.

## Test plan
- Reset, W=4, default MAX_VAL → count=15, at_max=1, at_min=0, changed=0. Assert rst mid-operation at count=7 → count=15 immediately, without waiting for a clock edge.
- Debounce disabled, WRAP=1: three dec presses from 15 → 14, 13, 12, each 2 edges after first low sample, with one changed pulse per press. From 0, one dec → 15; from 15, one inc → 0.
- WRAP=0, MAX_VAL=9: load 12 → count=9, at_max=1. Inc press → count stays 9, changed stays 0. Dec from 0 → stays 0, at_min=1.
- Simultaneous events: inc and dec pressed in the same cycle at count=5 → count stays 5, changed=0. Load(3) together with inc → count=3.
- BUTTON_DEBOUNCE_EN, DEB_CYCLES=4: a 3-cycle low glitch → no change. A button held low 20 cycles from count=15 → count=14 exactly at k+6, with a single step and no repeat.
- Button held low across reset deassertion → exactly one step after the nominal latency. No press is generated on release.
